// File: rtl/exec_phase_unit.sv
// Twelve-phase strobe generator with a three-step micro-op ALU (steps on phases 4/6/8).
// Optional macro ALU_STACK_SCALE_EN: arithmetic right-shift of esp immediates by STACK_SHIFT.
module exec_phase_unit #(
  parameter int unsigned STACK_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ope,
  input  logic [31:0] operand,
  input  logic [3:0]  num_of_ope,
  input  logic [3:0]  reg_load_1,
  input  logic [3:0]  reg_load_2,
  input  logic [3:0]  reg_load_3,
  output logic        clock_1,
  output logic        clock_2,
  output logic        clock_3,
  output logic        clock_4,
  output logic        clock_5,
  output logic        clock_6,
  output logic        clock_7,
  output logic        clock_8,
  output logic        clock_9,
  output logic        clock_10,
  output logic        clock_11,
  output logic        clock_12,
  output logic [31:0] alu_result,
  output logic [3:0]  selected_reg_load,
  output logic        zero_flag
);

  localparam int unsigned NPH = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 4;
  localparam int unsigned SHIFT_UNUSED = STACK_SHIFT;

  logic [NPH-1:0] phase_q;
  logic [NPH-1:0] phase_d;

  logic [7:0]           opcode;
  logic [7:0]           modrm;
  logic [7:0]           imm8;
  logic signed [DW-1:0] imm_sext;
  logic [DW-1:0]        delta;
  logic [DW-1:0]        result_c;
  logic [RW-1:0]        load_c;
  logic [1:0]           num_eff;
  logic                 step1_c;
  logic                 step2_c;
  logic                 step3_c;
  logic                 step_valid_c;
  logic [10:0]          unused_bits;

  assign opcode   = ope[31:24];
  assign modrm    = ope[23:16];
  assign imm8     = ope[15:8];
  assign imm_sext = {{24{imm8[7]}}, imm8};
  assign unused_bits = {ope[7:0], modrm[2:0]};

  // Phase state register; idle (all-zero) only while in reset
  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  // Next phase: rotate, entering phase 1 from idle or after phase 12
  always_comb begin
    phase_d = NPH'(1);
    if (phase_q != '0 && !phase_q[NPH-1])
      phase_d = phase_q << 1;
  end

  always_comb begin
    clock_1  = phase_q[0];
    clock_2  = phase_q[1];
    clock_3  = phase_q[2];
    clock_4  = phase_q[3];
    clock_5  = phase_q[4];
    clock_6  = phase_q[5];
    clock_7  = phase_q[6];
    clock_8  = phase_q[7];
    clock_9  = phase_q[8];
    clock_10 = phase_q[9];
    clock_11 = phase_q[10];
    clock_12 = phase_q[11];
  end

  // Step qualification; counts above 3 behave as 3
  always_comb begin
    step1_c = phase_q[3];
    step2_c = phase_q[5];
    step3_c = phase_q[7];
    num_eff = (num_of_ope > 4'd3) ? 2'd3 : num_of_ope[1:0];
    step_valid_c = (step1_c && num_eff >= 2'd1) ||
                   (step2_c && num_eff >= 2'd2) ||
                   (step3_c && num_eff == 2'd3);
    load_c = '0;
    if (step1_c)      load_c = reg_load_1;
    else if (step2_c) load_c = reg_load_2;
    else if (step3_c) load_c = reg_load_3;
  end

  always_comb begin
    delta    = DW'(imm_sext);
`ifdef ALU_STACK_SCALE_EN
    if (modrm[2:0] == 3'b100) delta = DW'(imm_sext >>> STACK_SHIFT);
`endif
    result_c = operand;
    case (opcode)
      8'h55: if (step1_c)  result_c = operand - DW'(1);
      8'h5D: if (step2_c)  result_c = operand + DW'(1);
      8'h83: begin
        case (modrm[5:3])
          3'b000:  result_c = operand + delta;
          3'b101:  result_c = operand - delta;
          default: result_c = operand;
        endcase
      end
      8'h01: if (!step1_c) result_c = alu_result + operand;
      default: result_c = operand;
    endcase
  end

  // Result registers: update on valid steps, load code cleared on all other edges
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result        <= '0;
      selected_reg_load <= '0;
      zero_flag         <= 1'b0;
    end else begin
      selected_reg_load <= '0;
      if (step_valid_c) begin
        alu_result        <= result_c;
        selected_reg_load <= load_c;
        zero_flag         <= (result_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_exec_phase_unit.sv
// Directed bench for exec_phase_unit: phase rotation, step ALU ops, clamping and reset abort.
module tb_exec_phase_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ope, operand;
  logic [3:0]  num_of_ope, reg_load_1, reg_load_2, reg_load_3;
  logic        clock_1, clock_2, clock_3, clock_4, clock_5, clock_6;
  logic        clock_7, clock_8, clock_9, clock_10, clock_11, clock_12;
  logic [31:0] alu_result;
  logic [3:0]  selected_reg_load;
  logic        zero_flag;
  logic [12:1] strobes;

  int total = 0;
  int bad   = 0;

  exec_phase_unit #(.STACK_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .ope(ope), .operand(operand), .num_of_ope(num_of_ope),
    .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
    .clock_1(clock_1), .clock_2(clock_2), .clock_3(clock_3), .clock_4(clock_4),
    .clock_5(clock_5), .clock_6(clock_6), .clock_7(clock_7), .clock_8(clock_8),
    .clock_9(clock_9), .clock_10(clock_10), .clock_11(clock_11), .clock_12(clock_12),
    .alu_result(alu_result), .selected_reg_load(selected_reg_load), .zero_flag(zero_flag)
  );

  assign strobes = {clock_12, clock_11, clock_10, clock_9, clock_8, clock_7,
                    clock_6, clock_5, clock_4, clock_3, clock_2, clock_1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge at which phase p is showing
  task automatic wait_phase(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (strobes[p]) hit = 1'b1;
    end
    if (!hit) check("phase_timeout", 32'(strobes), 32'(1) << (p - 1));
  endtask

  // Drive step k inputs while its phase is showing, then move past the step edge
  task automatic do_step(input int k, input logic [31:0] opnd, input logic [3:0] rl);
    wait_phase(2 * k + 2);
    operand = opnd;
    case (k)
      1:       reg_load_1 = rl;
      2:       reg_load_2 = rl;
      default: reg_load_3 = rl;
    endcase
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ope = '0; operand = '0; num_of_ope = '0;
    reg_load_1 = '0; reg_load_2 = '0; reg_load_3 = '0;
    repeat (3) @(negedge clk);
    check("rst_strobes", 32'(strobes), 32'h0);
    check("rst_alu", alu_result, 32'h0);
    check("rst_sel", 32'(selected_reg_load), 32'h0);
    check("rst_zf", 32'(zero_flag), 32'h0);

    reset = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      check("phase_seq", 32'(strobes), 32'(1) << ((i - 1) % 12));
    end

    // push, two steps
    ope = 32'h5500_0000; num_of_ope = 4'd2;
    do_step(1, 32'h10, 4'd2);
    check("push_s1_alu", alu_result, 32'h0000_000F);
    check("push_s1_sel", 32'(selected_reg_load), 32'd2);
    check("push_gap_sel", 32'(selected_reg_load), 32'd2);
    @(negedge clk);
    check("push_clr_sel", 32'(selected_reg_load), 32'd0);
    do_step(2, 32'h10, 4'd5);
    check("push_s2_alu", alu_result, 32'h0000_0010);
    check("push_s2_sel", 32'(selected_reg_load), 32'd5);
    wait_phase(8);
    @(negedge clk);
    check("push_s3_sel", 32'(selected_reg_load), 32'd0);
    check("push_s3_alu", alu_result, 32'h0000_0010);

    // push wraps below zero
    num_of_ope = 4'd1;
    do_step(1, 32'h0, 4'd3);
    check("push_wrap", alu_result, 32'hFFFF_FFFF);
    check("push_wrap_zf", 32'(zero_flag), 32'd0);

    // 0x83 immediate forms
    ope = 32'h83C4_0800;
    do_step(1, 32'h20, 4'd4);
`ifdef ALU_STACK_SCALE_EN
    check("add_esp", alu_result, 32'h22);
`else
    check("add_esp", alu_result, 32'h28);
`endif
    ope = 32'h83EC_0400;
    do_step(1, 32'h20, 4'd4);
`ifdef ALU_STACK_SCALE_EN
    check("sub_esp", alu_result, 32'h1F);
`else
    check("sub_esp", alu_result, 32'h1C);
`endif
    ope = 32'h83D4_0800;
    do_step(1, 32'h20, 4'd4);
    check("imm_other", alu_result, 32'h20);
    ope = 32'h83C0_F800;
    do_step(1, 32'h20, 4'd4);
    check("add_neg_imm", alu_result, 32'h18);

    // accumulate add
    ope = 32'h0100_0000; num_of_ope = 4'd2;
    do_step(1, 32'h5, 4'd1);
    check("add_s1", alu_result, 32'h5);
    do_step(2, 32'h7, 4'd1);
    check("add_s2", alu_result, 32'hC);
    check("add_s2_zf", 32'(zero_flag), 32'd0);
    do_step(1, 32'hFFFF_FFFB, 4'd6);
    do_step(2, 32'h5, 4'd7);
    check("add_zero", alu_result, 32'h0);
    check("add_zero_zf", 32'(zero_flag), 32'd1);
    check("add_zero_sel", 32'(selected_reg_load), 32'd7);

    // pop over three steps
    ope = 32'h5D00_0000; num_of_ope = 4'd3;
    do_step(1, 32'h100, 4'd1);
    check("pop_s1", alu_result, 32'h100);
    check("pop_s1_zf", 32'(zero_flag), 32'd0);
    do_step(2, 32'h100, 4'd2);
    check("pop_s2", alu_result, 32'h101);
    do_step(3, 32'h200, 4'd3);
    check("pop_s3", alu_result, 32'h200);
    check("pop_s3_sel", 32'(selected_reg_load), 32'd3);

    // step count above 3 clamps to 3; plain move passes operand
    ope = 32'h8900_0000; num_of_ope = 4'hF;
    do_step(1, 32'hA, 4'd1);
    check("mov_s1", alu_result, 32'hA);
    do_step(2, 32'hB, 4'd2);
    do_step(3, 32'hC, 4'd9);
    check("clamp_s3", alu_result, 32'hC);
    check("clamp_s3_sel", 32'(selected_reg_load), 32'd9);

    // no valid steps for a full rotation
    ope = 32'h5500_0000; num_of_ope = 4'd0; operand = 32'h77;
    reg_load_1 = 4'd9; reg_load_2 = 4'd9; reg_load_3 = 4'd9;
    wait_phase(1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("idle_sel", 32'(selected_reg_load), 32'd0);
      check("idle_alu", alu_result, 32'hC);
    end

    // reset mid-sequence
    num_of_ope = 4'd2;
    wait_phase(6);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", 32'(strobes), 32'h0);
    check("midrst_alu", alu_result, 32'h0);
    check("midrst_sel", 32'(selected_reg_load), 32'h0);
    check("midrst_zf", 32'(zero_flag), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("restart_phase", 32'(strobes), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
